// File: rtl/app_dram_responder_pkg.sv
// app_dram_responder_pkg: FSM encodings, default timing and LFSR constants shared by the responder
package app_dram_responder_pkg;
    localparam logic [1:0] ST_CALIB = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;
    localparam int DEF_CALIB_CYCLES = 16;
    localparam int DEF_READ_LATENCY = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/app_dram_responder_fifo.sv
// app_dram_responder_fifo: show-ahead synchronous FIFO holding queued read addresses
module app_dram_responder_fifo #(
    parameter int DATA_WIDTH = 27,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH:0]   wp;
    logic [ADDR_WIDTH:0]   rp;
    assign empty = wp == rp;
    assign full  = wp == {~rp[ADDR_WIDTH], rp[ADDR_WIDTH-1:0]};
    assign rdata = mem[rp[ADDR_WIDTH-1:0]];
    // pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (ADDR_WIDTH+1)'(1);
            if (pop && !empty) rp <= rp + (ADDR_WIDTH+1)'(1);
        end
    end
    // storage is not reset; only the pointers define occupancy
    always_ff @(posedge i_clk) begin
        if (push && !full) mem[wp[ADDR_WIDTH-1:0]] <= wdata;
    end
endmodule

// File: rtl/app_dram_responder.sv
// app_dram_responder: BRAM-backed DRAM app-interface stand-in; APP_RESP_BUSY_INJECT_EN adds LFSR busy stalls
module app_dram_responder
    import app_dram_responder_pkg::*;
#(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = DEF_READ_LATENCY,
    parameter int REQ_FIFO_LOG2  = 3,
    parameter int CALIB_CYCLES   = DEF_CALIB_CYCLES
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ren,
    input  logic                      i_wen,
    input  logic [APP_ADDR_WIDTH-2:0] i_addr,
    input  logic [APP_DATA_WIDTH-1:0] i_data,
    input  logic [APP_MASK_WIDTH-1:0] i_mask,
    input  logic                      i_busy,
    output logic                      o_init_calib_complete,
    output logic [APP_DATA_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic                      o_busy
);
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    logic [1:0]                state;
    logic [CW-1:0]             cal_cnt;
    logic [LW-1:0]             lat_cnt;
    logic [MEM_DEPTH_LOG2-1:0] rd_idx;
    logic [MEM_DEPTH_LOG2-1:0] wr_idx;
    logic [APP_DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];
    logic [APP_ADDR_WIDTH-2:0] q_addr;
    logic                      q_empty;
    logic                      q_full;
    logic                      q_pop;
    logic                      wr_acc;
    logic                      rd_acc;
    logic                      cmd_block;
    logic                      unused_addr;
`ifdef APP_RESP_BUSY_INJECT_EN
    logic [15:0] lfsr;
    // free-running Fibonacci LFSR that randomly blocks commands to stress stall paths
    always_ff @(posedge i_clk) begin
        lfsr <= i_rst ? LFSR_SEED : {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
    assign cmd_block = lfsr[1:0] == 2'b00;
`else
    assign cmd_block = 1'b0;
`endif
    assign o_busy                = state == ST_CALIB || q_full || cmd_block;
    assign o_init_calib_complete = state != ST_CALIB;
    assign wr_acc                = i_wen && !o_busy && !i_rst;
    assign rd_acc                = i_ren && !o_busy && !i_rst;
    assign q_pop                 = state == ST_IDLE && !q_empty;
    assign wr_idx                = i_addr[MEM_DEPTH_LOG2+2:3];
    assign unused_addr           = ^{i_addr, q_addr};
    app_dram_responder_fifo #(
        .DATA_WIDTH(APP_ADDR_WIDTH - 1),
        .ADDR_WIDTH(REQ_FIFO_LOG2)
    ) u_req_fifo (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .push (rd_acc),
        .wdata(i_addr),
        .pop  (q_pop),
        .rdata(q_addr),
        .empty(q_empty),
        .full (q_full)
    );
    // byte-masked write; the store survives reset so data outlives recalibration
    always_ff @(posedge i_clk) begin
        if (wr_acc)
            for (int b = 0; b < APP_MASK_WIDTH; b++)
                if (!i_mask[b]) mem[wr_idx][b*8 +: 8] <= i_data[b*8 +: 8];
    end
    // calibration, single-read service with latency count, and busy-held return data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_CALIB;
            cal_cnt      <= '0;
            lat_cnt      <= '0;
            rd_idx       <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else begin
            case (state)
                ST_CALIB: begin
                    cal_cnt <= cal_cnt + CW'(1);
                    if (cal_cnt == CW'(CALIB_CYCLES - 1)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    o_data_valid <= 1'b0;
                    if (!q_empty) begin
                        state   <= ST_WAIT;
                        lat_cnt <= LW'(READ_LATENCY);
                        rd_idx  <= q_addr[MEM_DEPTH_LOG2+2:3];
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - LW'(1);
                    if (lat_cnt == LW'(1)) begin
                        o_data       <= mem[rd_idx];
                        o_data_valid <= 1'b1;
                        state        <= i_busy ? ST_HOLD : ST_IDLE;
                    end
                end
                default: begin
                    if (!i_busy) begin
                        o_data_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_app_dram_responder.sv
// tb_app_dram_responder: vector table, corner-case sequences and randomized traffic against a line-level model
module tb_app_dram_responder;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int ML = 10;
    localparam int RL = 8;
    localparam int QL = 3;
    localparam int CC = 16;

    typedef struct {
        logic [AW-2:0] wa;
        logic [DW-1:0] d;
        logic [MW-1:0] m;
        logic [AW-2:0] ra;
        logic [DW-1:0] exp;
    } vec_t;

    logic          clk = 0;
    logic          rst = 1;
    logic          ren = 0;
    logic          wen = 0;
    logic          busy_in = 0;
    logic [AW-2:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [MW-1:0] mask = '0;
    logic          calib;
    logic          dvalid;
    logic          obusy;
    logic [DW-1:0] rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic          mon_en = 0;
    logic          prev_v = 0;
    logic [DW-1:0] prev_d = '0;
    logic [DW-1:0] model [2**ML];
    logic [DW-1:0] exp_q [$];
    int            rise_t [$];
    vec_t          vt [7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    app_dram_responder #(
        .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .MEM_DEPTH_LOG2(ML),
        .READ_LATENCY(RL), .REQ_FIFO_LOG2(QL), .CALIB_CYCLES(CC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_ren(ren), .i_wen(wen), .i_addr(addr), .i_data(wdata),
        .i_mask(mask), .i_busy(busy_in), .o_init_calib_complete(calib), .o_data(rdata),
        .o_data_valid(dvalid), .o_busy(obusy)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [AW-2:0] a);
        return int'(a >> 3) % (2**ML);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic [DW-1:0] keep = '0;
        for (int b = 0; b < MW; b++) keep |= {{(DW-8){1'b0}}, {8{m[b]}}} << (8 * b);
        return (old & keep) | (d & ~keep);
    endfunction

    function automatic logic [AW-2:0] rnd_addr();
        return (AW-1)'(($urandom_range(0, 7) << (ML + 3)) | ($urandom_range(0, 15) << 3) | $urandom_range(0, 7));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic cmd(input bit r, input bit w, input logic [AW-2:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m, input bit acc);
        chk("busy_before_cmd", DW'(obusy), DW'(!acc));
        ren = r;
        wen = w;
        addr = a;
        wdata = d;
        mask = m;
        tick();
        ren = 0;
        wen = 0;
        if (acc) begin
            if (w) model[idx(a)] = merge(model[idx(a)], d, m);
            if (r) exp_q.push_back(model[idx(a)]);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!dvalid && n < 100);
        if (!dvalid) n = -1;
    endtask

    task automatic calib_check(input bit try_write);
        for (int i = 0; i < CC; i++) begin
            chk("calib_low", DW'(calib), '0);
            if (try_write && i == 3) cmd(0, 1, 'h30, {16{8'hC3}}, '0, 0);
            else begin
                chk("busy_in_calib", DW'(obusy), DW'(1));
                tick();
            end
        end
        chk("calib_done", DW'(calib), DW'(1));
        chk("busy_released", DW'(obusy), '0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("drain_outstanding", DW'(exp_q.size()), '0);
        repeat (RL * 3) tick();
    endtask

    always @(negedge clk) begin
        if (mon_en && dvalid && !prev_v) begin
            rise_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got data %h with no read outstanding", rdata);
            end else chk("mon_read_data", rdata, exp_q.pop_front());
        end
        if (mon_en && dvalid && prev_v) chk("hold_stable", rdata, prev_d);
        prev_v = dvalid;
        prev_d = rdata;
    end

    initial begin
        int lat;
        logic [DW-1:0] e;
        vt[0] = '{'h08, '0, '0, 'h08, '0};
        vt[1] = '{'h08, {16{8'hFF}}, 16'hFFF0, 'h08, 128'h00000000_00000000_00000000_FFFFFFFF};
        vt[2] = '{'h08, {16{8'h11}}, 16'h0FFF, 'h08, 128'h11111111_00000000_00000000_FFFFFFFF};
        vt[3] = '{'h2008, {16{8'h22}}, 16'hFF00, 'h0F, 128'h11111111_00000000_22222222_22222222};
        vt[4] = '{'h18, 128'h0123456789ABCDEF_FEDCBA9876543210, '0, 'h1D, 128'h0123456789ABCDEF_FEDCBA9876543210};
        vt[5] = '{'h18, {16{8'hEE}}, 16'hFFFF, 'h18, 128'h0123456789ABCDEF_FEDCBA9876543210};
        vt[6] = '{'h18, {16{8'hEE}}, 16'h7FFE, 'h18, 128'hEE23456789ABCDEF_FEDCBA98765432EE};

        do_reset();
        chk("reset_valid", DW'(dvalid), '0);
        chk("reset_data", rdata, '0);
        calib_check(0);
        cmd(0, 1, 'h30, {16{8'h5A}}, '0, 1);
        do_reset();
        calib_check(1);
        cmd(1, 0, 'h30, '0, '0, 1);
        wait_valid(lat);
        chk("calib_write_ignored", rdata, exp_q.pop_front());

        for (int i = 0; i < 7; i++) begin
            cmd(0, 1, vt[i].wa, vt[i].d, vt[i].m, 1);
            cmd(1, 0, vt[i].ra, '0, '0, 1);
            wait_valid(lat);
            chk($sformatf("vec%0d_data", i), rdata, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), DW'(lat), DW'(RL + 1));
            exp_q.delete();
        end

        cmd(1, 1, 'h10, {16{8'hA5}}, '0, 1);
        wait_valid(lat);
        chk("ren_wen_same_cycle", rdata, {16{8'hA5}});
        exp_q.delete();

        cmd(0, 1, 'h40, 128'hCAFEF00D_DEADBEEF_01020304_A0B0C0D0, '0, 1);
        cmd(1, 0, 'h40, '0, '0, 1);
        e = exp_q.pop_front();
        repeat (RL) tick();
        chk("bp_not_yet_valid", DW'(dvalid), '0);
        busy_in = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid_held", DW'(dvalid), DW'(1));
            chk("bp_data_stable", rdata, e);
            if (i == 5) busy_in = 0;
        end
        tick();
        chk("bp_valid_dropped", DW'(dvalid), '0);

        for (int k = 0; k < 10; k++) cmd(0, 1, (AW-1)'((32 + k) << 3), {$urandom(), $urandom(), $urandom(), $urandom()}, '0, 1);
        repeat (2) tick();
        rise_t.delete();
        mon_en = 1;
        cmd(1, 0, (AW-1)'(32 << 3), '0, '0, 1);
        for (int k = 1; k <= 9; k++) cmd(1, 0, (AW-1)'((32 + k) << 3), '0, '0, k <= 8);
        drain();
        chk("qfull_result_count", DW'(rise_t.size()), DW'(9));
        for (int k = 1; k < rise_t.size(); k++) chk($sformatf("qfull_spacing%0d", k), DW'(rise_t[k] - rise_t[k-1]), DW'(RL + 1));

        cmd(1, 0, 'h08, '0, '0, 1);
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        exp_q.delete();
        calib_check(0);
        cmd(1, 0, 'h08, '0, '0, 1);
        drain();

        for (int i = 0; i < 16; i++) cmd(0, 1, (AW-1)'(i << 3), {$urandom(), $urandom(), $urandom(), $urandom()}, '0, 1);
        for (int it = 0; it < 400; it++) begin
            int op;
            logic [AW-2:0] a;
            busy_in = $urandom_range(0, 3) == 0;
            a = rnd_addr();
            op = $urandom_range(0, 3);
            if (exp_q.size() == 0 && op == 0) cmd(0, 1, a, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()), 1);
            else if (exp_q.size() == 0 && op == 1) cmd(1, 1, a, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()), 1);
            else if (exp_q.size() < 4 && op == 2) cmd(1, 0, a, '0, '0, 1);
            else tick();
        end
        busy_in = 0;
        drain();
        mon_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
